// File: rtl/wb_arb_pkg.sv
// Shared types and Wishbone constants for the
// round-robin burst arbiter.
package wb_arb_pkg;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_GRANT = 1'b1
  } arb_state_e;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_END     = 3'b111;
  localparam logic [1:0] BTE_LINEAR  = 2'b00;

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin picker: scans from
// last+1 upward (mod NUM_M) for the first requester.
module wb_rr_pick
  import wb_arb_pkg::*;
#(
  parameter int NUM_M = 2,
  parameter int IW    = (NUM_M > 1) ? $clog2(NUM_M) : 1
) (
  input  logic [NUM_M-1:0] req_i,
  input  logic [IW-1:0]    last_i,
  output logic [NUM_M-1:0] gnt_o,
  output logic [IW-1:0]    idx_o,
  output logic             any_o
);

  logic found;
  int   j;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    j     = 0;
    for (int k = 1; k <= NUM_M; k++) begin
      j = (int'(last_i) + k) % NUM_M;
      for (int i = 0; i < NUM_M; i++) begin
        if (!found && (i == j) && req_i[i]) begin
          found    = 1'b1;
          gnt_o[i] = 1'b1;
          idx_o    = IW'(i);
        end
      end
    end
  end

  assign any_o = |req_i;

endmodule

// File: rtl/wb_stream_burst_arbiter.sv
// Shares one Wishbone master port between NUM_M
// burst masters, whole-cycle grants plus ack watchdog.
module wb_stream_burst_arbiter
  import wb_arb_pkg::*;
#(
  parameter int NUM_M   = 2,
  parameter int WB_AW   = 32,
  parameter int WB_DW   = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_n_i,
  input  logic [NUM_M*WB_AW-1:0]   m_adr_i,
  input  logic [NUM_M*WB_DW-1:0]   m_dat_i,
  input  logic [NUM_M*WB_DW/8-1:0] m_sel_i,
  input  logic [NUM_M-1:0]         m_we_i,
  input  logic [NUM_M-1:0]         m_cyc_i,
  input  logic [NUM_M-1:0]         m_stb_i,
  input  logic [NUM_M*3-1:0]       m_cti_i,
  input  logic [NUM_M*2-1:0]       m_bte_i,
  output logic [WB_DW-1:0]         m_dat_o,
  output logic [NUM_M-1:0]         m_ack_o,
  output logic [NUM_M-1:0]         m_err_o,
  output logic [WB_AW-1:0]         s_adr_o,
  output logic [WB_DW-1:0]         s_dat_o,
  output logic [WB_DW/8-1:0]       s_sel_o,
  output logic                     s_we_o,
  output logic [2:0]               s_cti_o,
  output logic [1:0]               s_bte_o,
  output logic                     s_cyc_o,
  output logic                     s_stb_o,
  input  logic [WB_DW-1:0]         s_dat_i,
  input  logic                     s_ack_i,
  input  logic                     s_err_i,
  output logic [NUM_M-1:0]         gnt_o
);

  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;
  localparam int CW = $clog2(TIMEOUT + 2);
  localparam int SW = WB_DW / 8;
  localparam logic [CW-1:0] WD_LAST =
    (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  arb_state_e       state_q, state_d;
  logic [NUM_M-1:0] gnt_q, gnt_d;
  logic [IW-1:0]    last_q, last_d;
  logic [CW-1:0]    wd_q, wd_d;

  logic [NUM_M-1:0] pick_gnt;
  logic [IW-1:0]    pick_idx;
  logic             pick_any;

  logic             g_cyc, g_stb, g_we;
  logic [WB_AW-1:0] g_adr;
  logic [WB_DW-1:0] g_dat;
  logic [SW-1:0]    g_sel;
  logic [2:0]       g_cti;
  logic [1:0]       g_bte;
  logic             granted, tmo;

  wb_rr_pick #(
    .NUM_M (NUM_M),
    .IW    (IW)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .idx_o  (pick_idx),
    .any_o  (pick_any)
  );

  // gnt_q is zero outside GRANT, so the mux idles at 0
  always_comb begin
    g_cyc = 1'b0;
    g_stb = 1'b0;
    g_we  = 1'b0;
    g_adr = '0;
    g_dat = '0;
    g_sel = '0;
    g_cti = '0;
    g_bte = '0;
    for (int k = 0; k < NUM_M; k++) begin
      if (gnt_q[k]) begin
        g_cyc = m_cyc_i[k];
        g_stb = m_stb_i[k];
        g_we  = m_we_i[k];
        g_adr = m_adr_i[k*WB_AW +: WB_AW];
        g_dat = m_dat_i[k*WB_DW +: WB_DW];
        g_sel = m_sel_i[k*SW +: SW];
        g_cti = m_cti_i[k*3 +: 3];
        g_bte = m_bte_i[k*2 +: 2];
      end
    end
  end

  assign granted = (state_q == S_GRANT);

  // a slave response in the final cycle beats the watchdog
  assign tmo = (TIMEOUT != 0) && granted && g_stb &&
               !s_ack_i && !s_err_i && (wd_q == WD_LAST);

  always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
    if (!wb_rst_n_i) begin
      state_q <= S_IDLE;
      gnt_q   <= '0;
      last_q  <= IW'(NUM_M - 1);
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    wd_d    = wd_q;
    unique case (state_q)
      S_IDLE: begin
        wd_d = '0;
        if (pick_any) begin
          state_d = S_GRANT;
          gnt_d   = pick_gnt;
          last_d  = pick_idx;
        end
      end
      S_GRANT: begin
        if (s_ack_i || s_err_i || (TIMEOUT == 0))
          wd_d = '0;
        else if (g_stb)
          wd_d = wd_q + 1'b1;
        if (!g_cyc || tmo) begin
          state_d = S_IDLE;
          gnt_d   = '0;
        end
      end
      default: begin
        state_d = S_IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  always_comb begin
    s_cyc_o = granted && g_cyc && !tmo;
    s_stb_o = granted && g_stb && !tmo;
    s_adr_o = g_adr;
    s_dat_o = g_dat;
    s_sel_o = g_sel;
    s_we_o  = g_we;
    s_cti_o = g_cti;
    s_bte_o = g_bte;
    m_dat_o = s_dat_i;
    m_ack_o = gnt_q & {NUM_M{s_ack_i}};
    m_err_o = gnt_q & {NUM_M{s_err_i | tmo}};
    gnt_o   = gnt_q;
  end

endmodule

// File: tb/tb_wb_stream_burst_arbiter.sv
// Directed bench: vector table for bursts and err routing,
// hand sequences for rotation, watchdog and reset.
module tb_wb_stream_burst_arbiter;

  localparam int NM = 2;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 16;
  localparam logic [AW-1:0] A0 = 32'h1000_0000;
  localparam logic [AW-1:0] A1 = 32'h2000_0000;

  logic            clk, rst_n;
  logic [NM*AW-1:0] m_adr;
  logic [NM*DW-1:0] m_dat;
  logic [NM*DW/8-1:0] m_sel;
  logic [NM-1:0]   m_we, m_cyc, m_stb;
  logic [NM*3-1:0] m_cti;
  logic [NM*2-1:0] m_bte;
  logic [DW-1:0]   m_dat_o;
  logic [NM-1:0]   m_ack, m_err, gnt;
  logic [AW-1:0]   s_adr;
  logic [DW-1:0]   s_dat_o, s_dat_i;
  logic [DW/8-1:0] s_sel;
  logic            s_we, s_cyc, s_stb;
  logic [2:0]      s_cti;
  logic [1:0]      s_bte;
  logic            s_ack, s_err;

  int n_cmp = 0;
  int n_bad = 0;

  wb_stream_burst_arbiter #(
    .NUM_M(NM), .WB_AW(AW), .WB_DW(DW), .TIMEOUT(TO)
  ) dut (
    .wb_clk_i   (clk),
    .wb_rst_n_i (rst_n),
    .m_adr_i    (m_adr),
    .m_dat_i    (m_dat),
    .m_sel_i    (m_sel),
    .m_we_i     (m_we),
    .m_cyc_i    (m_cyc),
    .m_stb_i    (m_stb),
    .m_cti_i    (m_cti),
    .m_bte_i    (m_bte),
    .m_dat_o    (m_dat_o),
    .m_ack_o    (m_ack),
    .m_err_o    (m_err),
    .s_adr_o    (s_adr),
    .s_dat_o    (s_dat_o),
    .s_sel_o    (s_sel),
    .s_we_o     (s_we),
    .s_cti_o    (s_cti),
    .s_bte_o    (s_bte),
    .s_cyc_o    (s_cyc),
    .s_stb_o    (s_stb),
    .s_dat_i    (s_dat_i),
    .s_ack_i    (s_ack),
    .s_err_i    (s_err),
    .gnt_o      (gnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog_time: sim time limit hit");
    $fatal(1, "bench time limit");
  end

  typedef struct {
    logic       rst;
    logic [1:0] cyc;
    logic [1:0] stb;
    logic       ack;
    logic       err;
    logic       scyc;
    logic       sstb;
    logic [1:0] gnt;
    logic [1:0] mack;
    logic [1:0] merr;
  } vec_t;

  vec_t tv[$];

  task automatic chk(input string nm,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic logic [AW-1:0] exp_adr(
    input logic [1:0] g);
    if (g == 2'b01) return A0;
    if (g == 2'b10) return A1;
    return '0;
  endfunction

  function automatic logic [2:0] exp_cti(
    input logic [1:0] g);
    if (g == 2'b01) return 3'b010;
    if (g == 2'b10) return 3'b111;
    return 3'b000;
  endfunction

  task automatic do_reset();
    rst_n = 1'b0;
    m_cyc = '0;
    m_stb = '0;
    s_ack = 1'b0;
    s_err = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic drive(input logic [1:0] c,
                       input logic [1:0] s,
                       input logic a, input logic e);
    m_cyc = c;
    m_stb = s;
    s_ack = a;
    s_err = e;
  endtask

  function automatic vec_t mk(
    input logic r, input logic [1:0] c,
    input logic [1:0] s, input logic a,
    input logic e, input logic ec,
    input logic es, input logic [1:0] eg,
    input logic [1:0] ea, input logic [1:0] ee);
    vec_t v;
    v.rst = r;  v.cyc = c;   v.stb = s;
    v.ack = a;  v.err = e;   v.scyc = ec;
    v.sstb = es; v.gnt = eg; v.mack = ea;
    v.merr = ee;
    return v;
  endfunction

  int errs;
  logic [1:0] eg;
  logic [1:0] rel;

  initial begin
    rst_n   = 1'b1;
    m_adr   = {A1, A0};
    m_dat   = {32'hBBBB_0001, 32'hAAAA_0000};
    m_sel   = '1;
    m_we    = '0;
    m_cti   = {3'b111, 3'b010};
    m_bte   = '0;
    m_cyc   = '0;
    m_stb   = '0;
    s_dat_i = 32'hC0DE_F00D;
    s_ack   = 1'b0;
    s_err   = 1'b0;

    // single master 8-beat burst, stale ack after release
    tv.push_back(mk(1,2'b00,2'b00,0,0, 0,0,2'b00,2'b00,2'b00));
    tv.push_back(mk(0,2'b01,2'b01,0,0, 0,0,2'b00,2'b00,2'b00));
    for (int b = 0; b < 8; b++)
      tv.push_back(mk(0,2'b01,2'b01,1,0, 1,1,2'b01,2'b01,2'b00));
    tv.push_back(mk(0,2'b00,2'b00,0,0, 0,0,2'b01,2'b00,2'b00));
    tv.push_back(mk(0,2'b00,2'b00,1,0, 0,0,2'b00,2'b00,2'b00));
    // both request from reset, turnaround, err routing
    tv.push_back(mk(1,2'b11,2'b11,0,0, 0,0,2'b00,2'b00,2'b00));
    tv.push_back(mk(0,2'b11,2'b11,1,0, 1,1,2'b01,2'b01,2'b00));
    tv.push_back(mk(0,2'b11,2'b11,1,0, 1,1,2'b01,2'b01,2'b00));
    tv.push_back(mk(0,2'b10,2'b10,0,0, 0,0,2'b01,2'b00,2'b00));
    tv.push_back(mk(0,2'b10,2'b10,1,0, 0,0,2'b00,2'b00,2'b00));
    tv.push_back(mk(0,2'b10,2'b10,1,0, 1,1,2'b10,2'b10,2'b00));
    tv.push_back(mk(0,2'b10,2'b10,0,1, 1,1,2'b10,2'b00,2'b10));
    tv.push_back(mk(0,2'b10,2'b10,1,0, 1,1,2'b10,2'b10,2'b00));
    tv.push_back(mk(0,2'b00,2'b00,0,0, 0,0,2'b10,2'b00,2'b00));
    tv.push_back(mk(0,2'b00,2'b00,0,0, 0,0,2'b00,2'b00,2'b00));

    for (int i = 0; i < tv.size(); i++) begin
      if (tv[i].rst) do_reset();
      @(negedge clk);
      drive(tv[i].cyc, tv[i].stb, tv[i].ack, tv[i].err);
      #1;
      chk($sformatf("v%0d_scyc", i), 64'(s_cyc), 64'(tv[i].scyc));
      chk($sformatf("v%0d_sstb", i), 64'(s_stb), 64'(tv[i].sstb));
      chk($sformatf("v%0d_gnt", i), 64'(gnt), 64'(tv[i].gnt));
      chk($sformatf("v%0d_mack", i), 64'(m_ack), 64'(tv[i].mack));
      chk($sformatf("v%0d_merr", i), 64'(m_err), 64'(tv[i].merr));
      chk($sformatf("v%0d_adr", i), 64'(s_adr),
          64'(exp_adr(tv[i].gnt)));
      chk($sformatf("v%0d_cti", i), 64'(s_cti),
          64'(exp_cti(tv[i].gnt)));
    end
    chk("rdata_bcast", 64'(m_dat_o), 64'(32'hC0DE_F00D));

    // continuous re-requests alternate grants
    do_reset();
    eg = 2'b01;
    for (int g = 0; g < 20; g++) begin
      @(negedge clk);
      drive(2'b11, 2'b11, 0, 0);
      #1;
      chk($sformatf("rr%0d_idle", g), 64'(gnt), 64'(0));
      for (int b = 0; b < 4; b++) begin
        @(negedge clk);
        drive(2'b11, 2'b11, 1, 0);
        #1;
        chk($sformatf("rr%0d_gnt", g), 64'(gnt), 64'(eg));
        chk($sformatf("rr%0d_ack", g), 64'(m_ack), 64'(eg));
      end
      @(negedge clk);
      rel = ~eg;
      drive(rel, rel, 0, 0);
      #1;
      chk($sformatf("rr%0d_rel", g), 64'(s_cyc), 64'(0));
      eg = ~eg;
    end

    // watchdog fires on the 16th stalled clock
    do_reset();
    @(negedge clk);
    drive(2'b11, 2'b11, 0, 0);
    errs = 0;
    for (int n = 1; n <= TO; n++) begin
      @(negedge clk);
      #1;
      errs += int'(m_err[0]) + int'(m_err[1]);
      if (n < TO) begin
        chk($sformatf("wd%0d_scyc", n), 64'(s_cyc), 64'(1));
      end else begin
        chk("wd_fire_scyc", 64'(s_cyc), 64'(0));
        chk("wd_fire_sstb", 64'(s_stb), 64'(0));
        chk("wd_fire_err", 64'(m_err), 64'(2'b01));
        chk("wd_fire_gnt", 64'(gnt), 64'(2'b01));
      end
    end
    @(negedge clk);
    #1;
    errs += int'(m_err[0]) + int'(m_err[1]);
    chk("wd_turn_gnt", 64'(gnt), 64'(0));
    chk("wd_err_once", 64'(errs), 64'(1));
    @(negedge clk);
    #1;
    chk("wd_next_gnt", 64'(gnt), 64'(2'b10));
    chk("wd_next_scyc", 64'(s_cyc), 64'(1));

    // ack exactly at the limit wins over the watchdog
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b01, 0, 0);
    for (int n = 1; n < TO; n++) @(negedge clk);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("wdack_err", 64'(m_err), 64'(0));
    chk("wdack_ack", 64'(m_ack), 64'(2'b01));
    chk("wdack_scyc", 64'(s_cyc), 64'(1));
    @(negedge clk);
    s_ack = 1'b0;
    #1;
    chk("wdack_held", 64'(gnt), 64'(2'b01));
    chk("wdack_err2", 64'(m_err), 64'(0));

    // async reset mid-burst
    do_reset();
    @(negedge clk);
    drive(2'b01, 2'b01, 0, 0);
    @(negedge clk);
    s_ack = 1'b1;
    #1;
    chk("rst_pre_scyc", 64'(s_cyc), 64'(1));
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_scyc", 64'(s_cyc), 64'(0));
    chk("rst_gnt", 64'(gnt), 64'(0));
    chk("rst_ack", 64'(m_ack), 64'(0));
    @(negedge clk);
    rst_n = 1'b1;
    drive(2'b11, 2'b11, 0, 0);
    #1;
    chk("rst_idle", 64'(gnt), 64'(0));
    @(negedge clk);
    #1;
    chk("rst_first", 64'(gnt), 64'(2'b01));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
